// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - motion command codes, FSM state type and command helpers
package motion_pkg;

  localparam logic [2:0] CMD_STOP  = 3'd0;
  localparam logic [2:0] CMD_FWD   = 3'd1;
  localparam logic [2:0] CMD_BWD   = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Codes above CMD_RIGHT are not motions and collapse to STOP.
  function automatic logic [2:0] norm_cmd(input logic [2:0] cmd);
    return (cmd > CMD_RIGHT) ? CMD_STOP : cmd;
  endfunction

  function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
    return ((a == CMD_FWD)  && (b == CMD_BWD))   ||
           ((a == CMD_BWD)  && (b == CMD_FWD))   ||
           ((a == CMD_LEFT) && (b == CMD_RIGHT)) ||
           ((a == CMD_RIGHT) && (b == CMD_LEFT));
  endfunction

  // Returns {rotate[1:0], move[1:0]}; at most one bit is ever set.
  function automatic logic [3:0] cmd_to_sig(input logic [2:0] cmd);
    logic [3:0] sig;
    case (cmd)
      CMD_FWD:   sig = 4'b0010;
      CMD_BWD:   sig = 4'b0001;
      CMD_LEFT:  sig = 4'b1000;
      CMD_RIGHT: sig = 4'b0100;
      default:   sig = 4'b0000;
    endcase
    return sig;
  endfunction

endpackage

// File: rtl/motion_cmd_arbiter.sv
// rtl/motion_cmd_arbiter.sv - fixed-priority manual-over-auto command select
module motion_cmd_arbiter
  import motion_pkg::*;
(
  input  logic       man_valid,
  input  logic [2:0] man_cmd,
  input  logic       auto_valid,
  input  logic [2:0] auto_cmd,
  input  logic       slot_open,
  output logic       man_ready,
  output logic       auto_ready,
  output logic [2:0] sel_cmd,
  output logic       sel_src,
  output logic       accept
);

  assign man_ready  = slot_open;
  assign auto_ready = slot_open && !man_valid;
  assign sel_src    = man_valid;
  assign sel_cmd    = norm_cmd(man_valid ? man_cmd : auto_cmd);
  assign accept     = (man_valid && man_ready) || (auto_valid && auto_ready);

endmodule

// File: rtl/motion_scheduler.sv
// rtl/motion_scheduler.sv - timed motion steps with dead time between opposite directions
module motion_scheduler
  import motion_pkg::*;
#(
  parameter int STEP_CYCLES = 4,
  parameter int DEAD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       man_valid,
  input  logic [2:0] man_cmd,
  output logic       man_ready,
  input  logic       auto_valid,
  input  logic [2:0] auto_cmd,
  output logic       auto_ready,
  output logic [1:0] rotate_sig,
  output logic [1:0] move_sig,
  output logic       busy,
  output logic [2:0] cur_cmd,
  output logic       grant_src
);

  localparam int MAXC = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_SAT  = CW'(DEAD_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic [CW-1:0] dead_cnt_q, dead_cnt_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [2:0]    last_cmd_q, last_cmd_d;
  logic [2:0]    target_q, target_d;
  logic [2:0]    cur_cmd_q, cur_cmd_d;
  logic [1:0]    rotate_q, rotate_d;
  logic [1:0]    move_q, move_d;
  logic          grant_src_q, grant_src_d;

  logic       step_last;
  logic       slot_open;
  logic [2:0] sel_cmd;
  logic       sel_src;
  logic       accept;
  logic       go;
  logic       opp;

  assign step_last = (state_q == ST_RUN) && (step_cnt_q == STEP_LAST);
  assign slot_open = enable && ((state_q == ST_IDLE) || step_last);

  motion_cmd_arbiter u_arb (
    .man_valid  (man_valid),
    .man_cmd    (man_cmd),
    .auto_valid (auto_valid),
    .auto_cmd   (auto_cmd),
    .slot_open  (slot_open),
    .man_ready  (man_ready),
    .auto_ready (auto_ready),
    .sel_cmd    (sel_cmd),
    .sel_src    (sel_src),
    .accept     (accept)
  );

  assign go  = accept && (sel_cmd != CMD_STOP);
  assign opp = is_opposite(sel_cmd, last_cmd_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_cnt_q  <= '0;
      dead_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      last_cmd_q  <= CMD_STOP;
      target_q    <= CMD_STOP;
      cur_cmd_q   <= CMD_STOP;
      rotate_q    <= 2'b00;
      move_q      <= 2'b00;
      grant_src_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      dead_cnt_q  <= dead_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      last_cmd_q  <= last_cmd_d;
      target_q    <= target_d;
      cur_cmd_q   <= cur_cmd_d;
      rotate_q    <= rotate_d;
      move_q      <= move_d;
      grant_src_q <= grant_src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (go) state_d = opp ? ST_DEAD : ST_RUN;
        ST_RUN:  if (step_last) state_d = go ? (opp ? ST_DEAD : ST_RUN) : ST_IDLE;
        ST_DEAD: if (dead_cnt_q == DEAD_LAST) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    step_cnt_d  = '0;
    dead_cnt_d  = '0;
    idle_cnt_d  = '0;
    last_cmd_d  = last_cmd_q;
    target_d    = CMD_STOP;
    cur_cmd_d   = CMD_STOP;
    grant_src_d = accept ? sel_src : grant_src_q;
    case (state_d)
      ST_IDLE: begin
        // Only an uninterrupted idle stretch may forget the previous direction.
        if (state_q == ST_IDLE) begin
          idle_cnt_d = (idle_cnt_q == IDLE_SAT) ? idle_cnt_q : idle_cnt_q + CW'(1);
          if (idle_cnt_d == IDLE_SAT) last_cmd_d = CMD_STOP;
        end
      end
      ST_DEAD: begin
        if (state_q == ST_DEAD) begin
          dead_cnt_d = dead_cnt_q + CW'(1);
          target_d   = target_q;
        end else begin
          target_d   = sel_cmd;
        end
      end
      ST_RUN: begin
        if ((state_q == ST_RUN) && !step_last) begin
          step_cnt_d = step_cnt_q + CW'(1);
          cur_cmd_d  = cur_cmd_q;
        end else begin
          cur_cmd_d  = (state_q == ST_DEAD) ? target_q : sel_cmd;
          last_cmd_d = cur_cmd_d;
        end
      end
      default: ;
    endcase
    {rotate_d, move_d} = cmd_to_sig(cur_cmd_d);
  end

  assign rotate_sig = rotate_q;
  assign move_sig   = move_q;
  assign cur_cmd    = cur_cmd_q;
  assign grant_src  = grant_src_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_motion_scheduler.sv
// tb/tb_motion_scheduler.sv - scoreboard bench for motion_scheduler (STEP=4, DEAD=3)
module tb_motion_scheduler;
  import motion_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       man_valid = 1'b0;
  logic [2:0] man_cmd = 3'd0;
  logic       man_ready;
  logic       auto_valid = 1'b0;
  logic [2:0] auto_cmd = 3'd0;
  logic       auto_ready;
  logic [1:0] rotate_sig;
  logic [1:0] move_sig;
  logic       busy;
  logic [2:0] cur_cmd;
  logic       grant_src;

  motion_scheduler #(.STEP_CYCLES(4), .DEAD_CYCLES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .man_valid  (man_valid),
    .man_cmd    (man_cmd),
    .man_ready  (man_ready),
    .auto_valid (auto_valid),
    .auto_cmd   (auto_cmd),
    .auto_ready (auto_ready),
    .rotate_sig (rotate_sig),
    .move_sig   (move_sig),
    .busy       (busy),
    .cur_cmd    (cur_cmd),
    .grant_src  (grant_src)
  );

  always #5 clk = ~clk;

  // Observation word: {rotate, move, busy, man_ready, auto_ready, cur_cmd, grant_src}
  typedef struct {
    string      nm;
    logic [10:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [10:0] got;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {rotate_sig, move_sig, busy, man_ready, auto_ready, cur_cmd, grant_src};
      n_cmp++;
      if (got !== e.v) begin
        n_bad++;
        $display("FAIL %s: got rot=%b mv=%b busy=%b mr=%b ar=%b cmd=%0d gs=%b, expected rot=%b mv=%b busy=%b mr=%b ar=%b cmd=%0d gs=%b",
                 e.nm, got[10:9], got[8:7], got[6], got[5], got[4], got[3:1], got[0],
                 e.v[10:9], e.v[8:7], e.v[6], e.v[5], e.v[4], e.v[3:1], e.v[0]);
      end
    end
  end

  task automatic cyc(input logic en, input logic mv, input logic [2:0] mc,
                     input logic av, input logic [2:0] ac,
                     input logic [1:0] er, input logic [1:0] em, input logic eb,
                     input logic emr, input logic ear, input logic [2:0] ecc,
                     input logic egs, input string nm);
    exp_t x;
    enable     = en;
    man_valid  = mv;
    man_cmd    = mc;
    auto_valid = av;
    auto_cmd   = ac;
    x.nm = nm;
    x.v  = {er, em, eb, emr, ear, ecc, egs};
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic gs, input string nm);
    for (int i = 0; i < n; i++)
      cyc(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, CMD_STOP, gs, nm);
  endtask

  // Runs a step with no new offers; the last cycle opens the slot.
  task automatic run_step(input logic [1:0] er, input logic [1:0] em, input logic [2:0] cc,
                          input logic gs, input string nm);
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 0, 0, 0, er, em, 1, (i == 3), (i == 3), cc, gs, nm);
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, CMD_STOP, 0, "reset");
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, CMD_STOP, 0, "disabled_idle");

    cyc(1, 0, 0, 1, CMD_FWD, 2'b00, 2'b00, 0, 1, 1, CMD_STOP, 0, "t2_accept");
    run_step(2'b00, 2'b10, CMD_FWD, 0, "t2_run");
    idle(4, 0, "t2_idle");

    cyc(1, 1, CMD_LEFT, 1, CMD_RIGHT, 2'b00, 2'b00, 0, 1, 0, CMD_STOP, 0, "t3_both");
    run_step(2'b10, 2'b00, CMD_LEFT, 1, "t3_run");

    cyc(1, 0, 0, 1, CMD_FWD, 2'b00, 2'b00, 0, 1, 1, CMD_STOP, 1, "t4_accept");
    for (int k = 1; k <= 12; k++)
      cyc(1, 0, 0, (k < 12), CMD_FWD, 2'b00, 2'b10, 1, (k % 4 == 0), (k % 4 == 0), CMD_FWD, 0, "t4_seamless");

    cyc(1, 0, 0, 1, CMD_FWD, 2'b00, 2'b00, 0, 1, 1, CMD_STOP, 0, "t5_accept");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0, CMD_FWD, 0, "t5_fwd");
    cyc(1, 0, 0, 1, CMD_BWD, 2'b00, 2'b10, 1, 1, 1, CMD_FWD, 0, "t5_offer_bwd");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 1, CMD_FWD, 2'b00, 2'b00, 1, 0, 0, CMD_STOP, 0, "t5_dead");
    run_step(2'b00, 2'b01, CMD_BWD, 0, "t5_bwd");
    idle(3, 0, "t5_idle");
    cyc(1, 0, 0, 1, CMD_FWD, 2'b00, 2'b00, 0, 1, 1, CMD_STOP, 0, "t5_fwd_after_idle");
    run_step(2'b00, 2'b10, CMD_FWD, 0, "t5_no_dead");

    cyc(1, 0, 0, 1, CMD_FWD, 2'b00, 2'b00, 0, 1, 1, CMD_STOP, 0, "t6_accept");
    cyc(1, 0, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0, CMD_FWD, 0, "t6_run0");
    cyc(0, 0, 0, 1, CMD_BWD, 2'b00, 2'b10, 1, 0, 0, CMD_FWD, 0, "t6_disable");
    cyc(0, 0, 0, 1, CMD_BWD, 2'b00, 2'b00, 0, 0, 0, CMD_STOP, 0, "t6_aborted");
    cyc(1, 0, 0, 1, CMD_BWD, 2'b00, 2'b00, 0, 1, 1, CMD_STOP, 0, "t6_resume_opp");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, CMD_STOP, 0, "t6_dead");
    run_step(2'b00, 2'b01, CMD_BWD, 0, "t6_bwd");

    cyc(1, 1, 3'd7, 0, 0, 2'b00, 2'b00, 0, 1, 0, CMD_STOP, 0, "code7_accept");
    cyc(1, 0, 0, 1, CMD_RIGHT, 2'b00, 2'b00, 0, 1, 1, CMD_STOP, 1, "code7_stays_idle");
    rst = 1'b1;
    cyc(1, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0, CMD_RIGHT, 0, "rst_mid_run");
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, CMD_STOP, 0, "after_rst");
    idle(1, 0, "final_idle");

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
